half_adder: RTL and testbench

- Bit-parallel half adder: WIDTH independent lanes, each computing sum = a XOR b and carry = a AND b.
- Combinational outputs give the truth-table result in the same cycle.
- A registered copy with a valid flag gives a 1-cycle pipelined result.
- A saturating counter tallies lanes that produced a carry on accepted inputs.
- Used as a leaf arithmetic primitive and a bring-up/self-test block.

---
 rtl/half_adder_if.sv | 27 ++
 rtl/half_adder.sv | 68 ++++++
 tb/tb_half_adder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/half_adder_if.sv
// Operand/result bundle for the half_adder block.
// The master drives the operands and controls; the slave returns the combinational and registered results.
interface half_adder_if #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             clr_cnt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic             out_valid;
    logic [CNT_W-1:0] carry_cnt;

    modport master (
        output a, b, in_valid, clr_cnt,
        input  sum, carry, sum_q, carry_q, out_valid, carry_cnt
    );

    modport slave (
        input  a, b, in_valid, clr_cnt,
        output sum, carry, sum_q, carry_q, out_valid, carry_cnt
    );
endinterface

// File: rtl/half_adder.sv
// Bit-parallel half adder with a combinational result, a one-cycle registered copy,
// and a saturating tally of carry lanes on accepted inputs.
module half_adder #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    half_adder_if.slave  bus
);
    // Wide enough to hold cnt + WIDTH without overflowing before the saturation check.
    localparam int unsigned SumW = CNT_W + $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [WIDTH-1:0] sum_w, carry_w;
    logic [WIDTH-1:0] sum_d, sum_q, carry_d, carry_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [SumW-1:0]  pop, total;

    assign sum_w   = bus.a ^ bus.b;
    assign carry_w = bus.a & bus.b;

    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = bus.in_valid;
        if (bus.in_valid) begin
            sum_d   = sum_w;
            carry_d = carry_w;
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            pop = pop + SumW'(carry_w[i]);
        end
        total = SumW'(cnt_q) + pop;
        cnt_d = cnt_q;
        if (bus.clr_cnt) begin
            cnt_d = '0;
        end else if (bus.in_valid) begin
            cnt_d = (total > SumW'(CntMax)) ? CntMax : total[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sum       = sum_w;
    assign bus.carry     = carry_w;
    assign bus.sum_q     = sum_q;
    assign bus.carry_q   = carry_q;
    assign bus.out_valid = valid_q;
    assign bus.carry_cnt = cnt_q;
endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: three instances cover the 1-lane truth table and timing,
// the 4-lane case, and counter saturation with a 2-bit counter.
module tb_half_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    half_adder_if #(.WIDTH(1), .CNT_W(16)) if0 ();
    half_adder_if #(.WIDTH(4), .CNT_W(16)) if1 ();
    half_adder_if #(.WIDTH(1), .CNT_W(2))  if2 ();

    half_adder #(.WIDTH(1), .CNT_W(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    half_adder #(.WIDTH(4), .CNT_W(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    half_adder #(.WIDTH(1), .CNT_W(2))  u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sum;
        logic [3:0] carry;
    } vec_t;

    vec_t tt1[4];
    vec_t tt4[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        tt1[0] = '{4'h0, 4'h0, 4'h0, 4'h0};
        tt1[1] = '{4'h0, 4'h1, 4'h1, 4'h0};
        tt1[2] = '{4'h1, 4'h0, 4'h1, 4'h0};
        tt1[3] = '{4'h1, 4'h1, 4'h0, 4'h1};
        tt4[0] = '{4'b1100, 4'b1010, 4'b0110, 4'b1000};
        tt4[1] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tt4[2] = '{4'b1111, 4'b1111, 4'b0000, 4'b1111};
        tt4[3] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000};
        tt4[4] = '{4'b0101, 4'b0011, 4'b0110, 4'b0001};
        tt4[5] = '{4'b1001, 4'b0110, 4'b1111, 4'b0000};

        if0.a = '0; if0.b = '0; if0.in_valid = 1'b0; if0.clr_cnt = 1'b0;
        if1.a = '0; if1.b = '0; if1.in_valid = 1'b0; if1.clr_cnt = 1'b0;
        if2.a = '0; if2.b = '0; if2.in_valid = 1'b0; if2.clr_cnt = 1'b0;

        // Reset state, and combinational path alive during reset.
        @(negedge clk);
        check("rst sum_q", 32'(if0.sum_q), 32'h0);
        check("rst carry_q", 32'(if0.carry_q), 32'h0);
        check("rst out_valid", 32'(if0.out_valid), 32'h0);
        check("rst carry_cnt", 32'(if0.carry_cnt), 32'h0);
        if0.a = 1'b1; if0.b = 1'b1;
        #1;
        check("rst comb sum", 32'(if0.sum), 32'h0);
        check("rst comb carry", 32'(if0.carry), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Combinational truth tables, 10 time units apart.
        for (int i = 0; i < 4; i++) begin
            if0.a = tt1[i].a[0]; if0.b = tt1[i].b[0];
            #1;
            check($sformatf("tt1[%0d] sum", i), 32'(if0.sum), 32'(tt1[i].sum[0]));
            check($sformatf("tt1[%0d] carry", i), 32'(if0.carry), 32'(tt1[i].carry[0]));
            #9;
        end
        for (int i = 0; i < 6; i++) begin
            if1.a = tt4[i].a; if1.b = tt4[i].b;
            #1;
            check($sformatf("tt4[%0d] sum", i), 32'(if1.sum), 32'(tt4[i].sum));
            check($sformatf("tt4[%0d] carry", i), 32'(if1.carry), 32'(tt4[i].carry));
            #9;
        end

        // No acceptance without in_valid.
        @(negedge clk);
        check("idle out_valid", 32'(if0.out_valid), 32'h0);
        check("idle carry_cnt4", 32'(if1.carry_cnt), 32'h0);

        // One-cycle latency, then hold with a single-cycle out_valid pulse.
        if0.a = 1'b1; if0.b = 1'b1; if0.in_valid = 1'b1;
        @(negedge clk);
        check("lat sum_q", 32'(if0.sum_q), 32'h0);
        check("lat carry_q", 32'(if0.carry_q), 32'h1);
        check("lat out_valid", 32'(if0.out_valid), 32'h1);
        if0.in_valid = 1'b0; if0.a = 1'b0; if0.b = 1'b1;
        @(negedge clk);
        check("hold out_valid", 32'(if0.out_valid), 32'h0);
        check("hold sum_q", 32'(if0.sum_q), 32'h0);
        check("hold carry_q", 32'(if0.carry_q), 32'h1);
        check("hold carry_cnt", 32'(if0.carry_cnt), 32'h1);

        // Four lanes: counter adds the popcount of the carries.
        if1.a = 4'b1100; if1.b = 4'b1010; if1.in_valid = 1'b1;
        @(negedge clk);
        check("w4 sum_q", 32'(if1.sum_q), 32'h6);
        check("w4 carry_q", 32'(if1.carry_q), 32'h8);
        check("w4 cnt +1", 32'(if1.carry_cnt), 32'd1);
        if1.a = 4'b1111; if1.b = 4'b1111;
        @(negedge clk);
        check("w4 cnt +4", 32'(if1.carry_cnt), 32'd5);
        if1.in_valid = 1'b0;
        @(negedge clk);
        check("w4 cnt idle", 32'(if1.carry_cnt), 32'd5);
        check("w4 out_valid", 32'(if1.out_valid), 32'h0);

        // 2-bit counter saturates at 3; clear beats a simultaneous increment.
        if2.a = 1'b1; if2.b = 1'b1; if2.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("sat cnt[%0d]", k), 32'(if2.carry_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
        end
        if2.clr_cnt = 1'b1;
        @(negedge clk);
        check("sat clr", 32'(if2.carry_cnt), 32'd0);
        check("sat clr out_valid", 32'(if2.out_valid), 32'h1);
        if2.clr_cnt = 1'b0; if2.in_valid = 1'b0;

        // Asynchronous reset mid-cycle discards in-flight state.
        if0.a = 1'b1; if0.b = 1'b1; if0.in_valid = 1'b1;
        @(negedge clk);
        check("pre-rst out_valid", 32'(if0.out_valid), 32'h1);
        check("pre-rst carry_cnt", 32'(if0.carry_cnt), 32'd2);
        if0.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst sum_q", 32'(if0.sum_q), 32'h0);
        check("arst carry_q", 32'(if0.carry_q), 32'h0);
        check("arst out_valid", 32'(if0.out_valid), 32'h0);
        check("arst carry_cnt", 32'(if0.carry_cnt), 32'h0);
        check("arst carry_cnt4", 32'(if1.carry_cnt), 32'h0);
        if0.a = 1'b1; if0.b = 1'b0;
        #1;
        check("arst comb sum", 32'(if0.sum), 32'h1);
        check("arst comb carry", 32'(if0.carry), 32'h0);

        // First valid edge after release is accepted.
        @(negedge clk);
        rst_n = 1'b1;
        if0.in_valid = 1'b1;
        @(negedge clk);
        check("post-rst sum_q", 32'(if0.sum_q), 32'h1);
        check("post-rst carry_q", 32'(if0.carry_q), 32'h0);
        check("post-rst out_valid", 32'(if0.out_valid), 32'h1);
        check("post-rst carry_cnt", 32'(if0.carry_cnt), 32'h0);
        if0.in_valid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
